// File: rtl/mac_stream.sv
// Streaming signed dot-product engine: a product register feeds an accumulator
// that emits one (optionally saturated) sum per LEN operand pairs over valid/ready.
module mac_stream #(
    parameter int IN_WIDTH  = 12,
    parameter int ACC_WIDTH = 24,
    parameter int LEN       = 16,
    parameter int SATURATE  = 1,
    localparam int CNT_WIDTH = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic                        Clr_SI,
    input  logic                        InValid_SI,
    output logic                        InReady_SO,
    input  logic signed [IN_WIDTH-1:0]  In0_DI,
    input  logic signed [IN_WIDTH-1:0]  In1_DI,
    output logic                        OutValid_SO,
    input  logic                        OutReady_SI,
    output logic signed [ACC_WIDTH-1:0] Out_DO,
    output logic                        Ovf_SO,
    output logic [CNT_WIDTH-1:0]        Cnt_DO
);

    localparam int PROD_WIDTH = 2 * IN_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    generate
        if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_acc_width_check
            $error("mac_stream: ACC_WIDTH must be at least 2*IN_WIDTH");
        end
        if (LEN < 1) begin : g_len_check
            $error("mac_stream: LEN must be at least 1");
        end
    endgenerate

    logic signed [PROD_WIDTH-1:0] prod_q;
    logic                         prod_valid_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic                         sticky_q;
    logic                         out_valid_q;
    logic signed [ACC_WIDTH-1:0]  out_q;
    logic                         ovf_q;

    logic                         stall;
    logic                         advance;
    logic                         in_ready;
    logic                         transfer;
    logic signed [PROD_WIDTH-1:0] prod_d;

    logic                         frame_start;
    logic                         frame_last;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic                         sum_ovf;
    logic signed [ACC_WIDTH-1:0]  result;
    logic                         sticky_next;

    // A held result freezes the whole pipeline, including the product register.
    assign stall    = out_valid_q & ~OutReady_SI;
    assign advance  = ~stall;
    assign in_ready = Rst_RBI & ~Clr_SI & ~stall;
    assign transfer = InValid_SI & in_ready;
    assign prod_d   = In0_DI * In1_DI;

    always_comb begin
        frame_start = (cnt_q == '0);
        frame_last  = (cnt_q == CNT_WIDTH'(LEN - 1));
        acc_base    = frame_start ? '0 : acc_q;
        sum_wide    = {acc_base[ACC_WIDTH-1], acc_base}
                    + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
        sum_ovf     = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
        result      = sum_wide[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            result = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        sticky_next = (frame_start ? 1'b0 : sticky_q) | sum_ovf;
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            ovf_q        <= 1'b0;
        end else if (Clr_SI) begin
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (advance) begin
            prod_q       <= prod_d;
            prod_valid_q <= transfer;
            // Advancing with a valid result means it was taken this edge.
            out_valid_q  <= 1'b0;
            if (prod_valid_q) begin
                if (frame_last) begin
                    out_q       <= result;
                    ovf_q       <= sticky_next;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    sticky_q    <= 1'b0;
                end else begin
                    acc_q    <= result;
                    sticky_q <= sticky_next;
                    cnt_q    <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign InReady_SO  = in_ready;
    assign OutValid_SO = out_valid_q;
    assign Out_DO      = out_q;
    assign Ovf_SO      = ovf_q;
    assign Cnt_DO      = cnt_q;

endmodule

// File: tb/tb_mac_stream.sv
// Bench for mac_stream: LEN=4, LEN=16 (saturating and wrapping) and LEN=1 instances
// share one stimulus stream; a negedge monitor pops expected sums from scoreboard queues.
module tb_mac_stream;

    typedef struct packed {
        logic [23:0] sum;
        logic        ovf;
    } result_t;

    typedef struct packed {
        logic [3:0][11:0] a;
        logic [3:0][11:0] b;
        logic [23:0]      sum;
        logic             ovf;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic in_valid;
    logic out_ready;
    logic signed [11:0] in0;
    logic signed [11:0] in1;

    logic ready4, valid4, ovf4;
    logic signed [23:0] out4;
    logic [1:0] cnt4;
    logic ready16s, valid16s, ovf16s;
    logic signed [23:0] out16s;
    logic [3:0] cnt16s;
    logic ready16w, valid16w, ovf16w;
    logic signed [23:0] out16w;
    logic [3:0] cnt16w;
    logic ready1, valid1, ovf1;
    logic signed [23:0] out1;
    logic [0:0] cnt1;

    int errors = 0;
    int checks = 0;
    int mode = 4;
    int stall_cycles = 0;
    bit sb4_en = 1'b0;
    bit sb1_en = 1'b0;
    bit rand_done = 1'b0;
    result_t q4[$];
    result_t q1[$];
    frame_vec_t vecs[5];

    mac_stream #(.IN_WIDTH(12), .ACC_WIDTH(24), .LEN(4), .SATURATE(1)) dut4 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_valid),
        .InReady_SO(ready4), .In0_DI(in0), .In1_DI(in1), .OutValid_SO(valid4),
        .OutReady_SI(out_ready), .Out_DO(out4), .Ovf_SO(ovf4), .Cnt_DO(cnt4));

    mac_stream #(.IN_WIDTH(12), .ACC_WIDTH(24), .LEN(16), .SATURATE(1)) dut16s (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_valid),
        .InReady_SO(ready16s), .In0_DI(in0), .In1_DI(in1), .OutValid_SO(valid16s),
        .OutReady_SI(out_ready), .Out_DO(out16s), .Ovf_SO(ovf16s), .Cnt_DO(cnt16s));

    mac_stream #(.IN_WIDTH(12), .ACC_WIDTH(24), .LEN(16), .SATURATE(0)) dut16w (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_valid),
        .InReady_SO(ready16w), .In0_DI(in0), .In1_DI(in1), .OutValid_SO(valid16w),
        .OutReady_SI(out_ready), .Out_DO(out16w), .Ovf_SO(ovf16w), .Cnt_DO(cnt16w));

    mac_stream #(.IN_WIDTH(12), .ACC_WIDTH(24), .LEN(1), .SATURATE(1)) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Clr_SI(clr), .InValid_SI(in_valid),
        .InReady_SO(ready1), .In0_DI(in0), .In1_DI(in1), .OutValid_SO(valid1),
        .OutReady_SI(out_ready), .Out_DO(out1), .Ovf_SO(ovf1), .Cnt_DO(cnt1));

    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic sel_ready(input int which);
        if (which == 1) return ready1;
        if (which == 16) return ready16s;
        return ready4;
    endfunction

    function automatic logic sel_valid(input int which);
        if (which == 1) return valid1;
        if (which == 16) return valid16s;
        return valid4;
    endfunction

    function automatic frame_vec_t mk_vec(input int a0, a1, a2, a3, b0, b1, b2, b3,
                                          input int s, input bit o);
        frame_vec_t f;
        f.a[0] = 12'(a0); f.a[1] = 12'(a1); f.a[2] = 12'(a2); f.a[3] = 12'(a3);
        f.b[0] = 12'(b0); f.b[1] = 12'(b1); f.b[2] = 12'(b2); f.b[3] = 12'(b3);
        f.sum  = 24'(s);
        f.ovf  = o;
        return f;
    endfunction

    function automatic result_t mk_res(input int s, input bit o);
        result_t r;
        r.sum = 24'(s);
        r.ovf = o;
        return r;
    endfunction

    // Presents one pair and returns #1 after the edge that accepted it.
    task automatic apply_stimulus(input logic signed [11:0] a, input logic signed [11:0] b);
        in0 = a;
        in1 = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sel_ready(mode)) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            if (t == 0) stall_cycles++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL send_timeout: got no ready, expected ready within 200 cycles");
    endtask

    task automatic wait_valid(input int which, input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sel_valid(which)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no valid, expected valid within 200 cycles", name);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q4.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        result_t e;
        if (sb4_en && valid4 && out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb4_unexpected: got sum %0d, expected no result", out4);
            end else begin
                e = q4.pop_front();
                check_output("sb4_sum", out4, $signed(e.sum));
                check_output("sb4_ovf", ovf4, e.ovf);
            end
        end
        if (sb1_en && valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb1_unexpected: got sum %0d, expected no result", out1);
            end else begin
                e = q1.pop_front();
                check_output("sb1_sum", out1, $signed(e.sum));
                check_output("sb1_ovf", ovf1, e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [23:0] held;
        bit stable;

        vecs[0] = mk_vec(1, 2, -4, 7, 1, 3, 5, -1, -20, 1'b0);
        vecs[1] = mk_vec(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, 8388607, 1'b1);
        vecs[2] = mk_vec(-2048, -2048, -2048, -2048, 2047, 2047, 2047, 2047, -8388608, 1'b1);
        vecs[3] = mk_vec(2047, 2047, 2047, -2048, 2047, 2047, 2047, 2047, 4196351, 1'b1);
        vecs[4] = mk_vec(100, -1, 0, -2048, -100, -1, 5, 1, -12047, 1'b0);

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in0 = '0; in1 = '0;
        idle(2);
        check_output("reset_valid", valid4, 0);
        check_output("reset_out", out4, 0);
        check_output("reset_ovf", ovf4, 0);
        check_output("reset_cnt", cnt4, 0);
        check_output("reset_ready_low", ready4, 0);
        rst_n = 1'b1;
        #1;
        check_output("release_ready", ready4, 1);

        // First frame: result is registered by the edge after the last accept and
        // is therefore seen by the downstream at the second edge after it.
        sb4_en = 1'b1;
        q4.push_back(mk_res(-20, 1'b0));
        apply_stimulus(1, 1);
        apply_stimulus(2, 3);
        apply_stimulus(-4, 5);
        apply_stimulus(7, -1);
        check_output("lat_valid_k", valid4, 0);
        check_output("lat_cnt_k", cnt4, 3);
        idle(1);
        check_output("lat_valid_k1", valid4, 1);
        check_output("lat_out_k1", out4, -20);
        check_output("lat_cnt_k1", cnt4, 0);

        stall_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            q4.push_back(mk_res($signed(vecs[i].sum), vecs[i].ovf));
            for (int j = 0; j < 4; j++) begin
                apply_stimulus($signed(vecs[i].a[j]), $signed(vecs[i].b[j]));
            end
        end
        idle(4);
        check_output("table_drained", q4.size(), 0);
        check_output("table_no_bubble", stall_cycles, 0);

        // Backpressure: three frames streamed while the first result is held.
        do_reset();
        out_ready = 1'b0;
        q4.push_back(mk_res(8, 1'b0));
        q4.push_back(mk_res(36, 1'b0));
        q4.push_back(mk_res(-60, 1'b0));
        fork
            begin
                for (int i = 0; i < 4; i++) apply_stimulus(1, 2);
                for (int i = 0; i < 4; i++) apply_stimulus(3, 3);
                for (int i = 0; i < 4; i++) apply_stimulus(-3, 5);
            end
            begin
                wait_valid(4, "stall_wait");
                check_output("stall_ready_low", ready4, 0);
                held = out4;
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (out4 !== held || valid4 !== 1'b1 || ready4 !== 1'b0) stable = 1'b0;
                end
                check_output("stall_hold_stable", stable, 1);
                check_output("stall_held_value", held, 8);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        check_output("stall_drained", q4.size(), 0);

        // Clear mid-frame, then clear while a result is pending.
        do_reset();
        out_ready = 1'b1;
        apply_stimulus(5, 5);
        apply_stimulus(5, 5);
        idle(2);
        check_output("clr_pre_cnt", cnt4, 2);
        clr = 1'b1;
        @(negedge clk);
        check_output("clr_ready_low", ready4, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_output("clr_cnt", cnt4, 0);
        q4.push_back(mk_res(4, 1'b0));
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1);
        idle(4);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(2, 2);
        wait_valid(4, "clr_pend_wait");
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_output("clr_drops_pending", valid4, 0);
        out_ready = 1'b1;
        q4.push_back(mk_res(4, 1'b0));
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1);
        idle(4);
        check_output("clr_drained", q4.size(), 0);

        // Reset while a result is held and a new frame is partly in the pipeline.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(3, 1);
        apply_stimulus(7, 7);
        check_output("rst_pre_valid", valid4, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("rst_valid", valid4, 0);
        check_output("rst_out", out4, 0);
        check_output("rst_ovf", ovf4, 0);
        check_output("rst_cnt", cnt4, 0);
        check_output("rst_ready_low", ready4, 0);
        rst_n = 1'b1;
        #1;
        check_output("rst_release_ready", ready4, 1);
        out_ready = 1'b1;
        q4.push_back(mk_res(4, 1'b0));
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1);
        idle(4);
        check_output("rst_drained", q4.size(), 0);

        // LEN=16: sixteen most-negative squares, saturated versus wrapped.
        sb4_en = 1'b0;
        mode = 16;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) apply_stimulus(-2048, -2048);
        wait_valid(16, "len16_wait");
        check_output("sat_out", out16s, 8388607);
        check_output("sat_ovf", ovf16s, 1);
        check_output("wrap_valid", valid16w, 1);
        check_output("wrap_out", out16w, 0);
        check_output("wrap_ovf", ovf16w, 1);

        // LEN=1: every product is a frame, downstream ready is random.
        mode = 1;
        do_reset();
        sb1_en = 1'b1;
        rand_done = 1'b0;
        fork
            begin
                logic signed [11:0] a;
                logic signed [11:0] b;
                logic signed [23:0] p;
                for (int i = 0; i < 40; i++) begin
                    if (i == 0) begin a = -12'sd2048; b = -12'sd2048; end
                    else if (i == 1) begin a = 12'sd2047; b = -12'sd2048; end
                    else begin a = 12'($urandom); b = 12'($urandom); end
                    p = a * b;
                    q1.push_back(mk_res(p, 1'b0));
                    apply_stimulus(a, b);
                end
                rand_done = 1'b1;
            end
            begin
                for (int i = 0; i < 4000 && !rand_done; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        check_output("len1_drained", q1.size(), 0);
        check_output("len1_cnt", cnt1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
